// File: rtl/pipe_pkg.sv
// Shared pipeline types and defaults for the ID/EX boundary: control bundle
// layout, bubble constant and default field widths.
package pipe_pkg;

  localparam int DATA_W  = 32;
  localparam int REG_AW  = 5;
  localparam int FUNCT_W = 6;

  typedef struct packed {
    logic regDest;
    logic memRead;
    logic memToReg;
    logic aluOp;
    logic memWrite;
    logic aluSrc;
    logic regWrite;
    logic branch;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard check: the load in EX targets a register the ID instruction
// reads. Purely combinational; register index 0 never matches.
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              ex_memRead,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              uses_rt,
  output logic              hazard_o
);

  logic w_load_in_ex;
  logic w_rs_match;
  logic w_rt_match;

  assign w_load_in_ex = ex_valid & ex_memRead & (ex_rt != '0) & id_valid;
  assign w_rs_match   = (ex_rt == id_rs);
  assign w_rt_match   = (ex_rt == id_rt) & uses_rt;
  assign hazard_o     = w_load_in_ex & (w_rs_match | w_rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and
// downstream hold. Optional perf counters under ID_EX_PERF_CNT_EN.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_regDest,
  input  logic              id_memRead,
  input  logic              id_memToReg,
  input  logic              id_aluOp,
  input  logic              id_memWrite,
  input  logic              id_aluSrc,
  input  logic              id_regWrite,
  input  logic              id_branch,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc_plus4,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [5:0]        id_funct,
  input  logic              flush_i,
  input  logic              hold_i,
  output logic              ex_regDest,
  output logic              ex_memRead,
  output logic              ex_memToReg,
  output logic              ex_aluOp,
  output logic              ex_memWrite,
  output logic              ex_aluSrc,
  output logic              ex_regWrite,
  output logic              ex_branch,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc_plus4,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [5:0]        ex_funct,
  output logic              stall_o,
  output logic              hazard_o
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]       bubble_cnt_o,
  output logic [31:0]       flush_cnt_o
`endif
);

  import pipe_pkg::*;

  ctrl_t               r_ctrl;
  logic                r_valid;
  logic [DATA_W-1:0]   r_rs_data;
  logic [DATA_W-1:0]   r_rt_data;
  logic [DATA_W-1:0]   r_imm;
  logic [DATA_W-1:0]   r_pc_plus4;
  logic [REG_AW-1:0]   r_rs;
  logic [REG_AW-1:0]   r_rt;
  logic [REG_AW-1:0]   r_rd;
  logic [FUNCT_W-1:0]  r_funct;

  ctrl_t w_id_ctrl;
  logic  w_uses_rt;
  logic  w_hazard;
  logic  w_clear;

  assign w_id_ctrl = '{regDest:  id_regDest,
                       memRead:  id_memRead,
                       memToReg: id_memToReg,
                       aluOp:    id_aluOp,
                       memWrite: id_memWrite,
                       aluSrc:   id_aluSrc,
                       regWrite: id_regWrite,
                       branch:   id_branch};

  // rt is a source for R-type ALU ops, stores (data) and beq (compare).
  assign w_uses_rt = ~id_aluSrc | id_memWrite | id_branch;

  hazard_detect #(
    .REG_AW(REG_AW)
  ) u_hazard_detect (
    .ex_valid   (r_valid),
    .ex_memRead (r_ctrl.memRead),
    .ex_rt      (r_rt),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .uses_rt    (w_uses_rt),
    .hazard_o   (w_hazard)
  );

  assign hazard_o = w_hazard;
  assign stall_o  = w_hazard | hold_i;

  // Reset, flush and an unheld hazard all collapse to loading an all-zero bubble.
  assign w_clear = ~rst_n | flush_i | (~hold_i & w_hazard);

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_ctrl     <= CTRL_BUBBLE;
      r_valid    <= 1'b0;
      r_rs_data  <= '0;
      r_rt_data  <= '0;
      r_imm      <= '0;
      r_pc_plus4 <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rd       <= '0;
      r_funct    <= '0;
    end else if (!hold_i) begin
      r_ctrl     <= w_id_ctrl;
      r_valid    <= id_valid;
      r_rs_data  <= id_rs_data;
      r_rt_data  <= id_rt_data;
      r_imm      <= id_imm;
      r_pc_plus4 <= id_pc_plus4;
      r_rs       <= id_rs;
      r_rt       <= id_rt;
      r_rd       <= id_rd;
      r_funct    <= id_funct;
    end
  end

  assign ex_regDest  = r_ctrl.regDest;
  assign ex_memRead  = r_ctrl.memRead;
  assign ex_memToReg = r_ctrl.memToReg;
  assign ex_aluOp    = r_ctrl.aluOp;
  assign ex_memWrite = r_ctrl.memWrite;
  assign ex_aluSrc   = r_ctrl.aluSrc;
  assign ex_regWrite = r_ctrl.regWrite;
  assign ex_branch   = r_ctrl.branch;
  assign ex_valid    = r_valid;
  assign ex_rs_data  = r_rs_data;
  assign ex_rt_data  = r_rt_data;
  assign ex_imm      = r_imm;
  assign ex_pc_plus4 = r_pc_plus4;
  assign ex_rs       = r_rs;
  assign ex_rt       = r_rt;
  assign ex_rd       = r_rd;
  assign ex_funct    = r_funct;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] r_bubble_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (w_hazard && !flush_i && !hold_i) r_bubble_cnt <= r_bubble_cnt + 32'd1;
      if (flush_i) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign bubble_cnt_o = r_bubble_cnt;
  assign flush_cnt_o  = r_flush_cnt;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic against a transaction-level model of the EX slot.
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int BW = 158;

  logic clk = 1'b0;
  logic rst_n;
  logic id_regDest, id_memRead, id_memToReg, id_aluOp, id_memWrite, id_aluSrc, id_regWrite;
  logic id_branch, id_valid;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm, id_pc_plus4;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic [5:0]    id_funct;
  logic flush_i, hold_i;

  logic ex_regDest, ex_memRead, ex_memToReg, ex_aluOp, ex_memWrite, ex_aluSrc, ex_regWrite;
  logic ex_branch, ex_valid;
  logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc_plus4;
  logic [AW-1:0] ex_rs, ex_rt, ex_rd;
  logic [5:0]    ex_funct;
  logic stall_o, hazard_o;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_cnt_o, flush_cnt_o;
`endif

  id_ex_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_regDest(id_regDest), .id_memRead(id_memRead), .id_memToReg(id_memToReg),
    .id_aluOp(id_aluOp), .id_memWrite(id_memWrite), .id_aluSrc(id_aluSrc),
    .id_regWrite(id_regWrite), .id_branch(id_branch), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_pc_plus4(id_pc_plus4), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_funct(id_funct), .flush_i(flush_i), .hold_i(hold_i),
    .ex_regDest(ex_regDest), .ex_memRead(ex_memRead), .ex_memToReg(ex_memToReg),
    .ex_aluOp(ex_aluOp), .ex_memWrite(ex_memWrite), .ex_aluSrc(ex_aluSrc),
    .ex_regWrite(ex_regWrite), .ex_branch(ex_branch), .ex_valid(ex_valid),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_pc_plus4(ex_pc_plus4), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_funct(ex_funct), .stall_o(stall_o), .hazard_o(hazard_o)
`ifdef ID_EX_PERF_CNT_EN
    , .bubble_cnt_o(bubble_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks_total++;
    if (obs === exp) checks_passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Model of what the EX slot should hold: the whole instruction as one word,
  // plus the three fields the hazard rule needs.
  logic [BW-1:0] m_slot;
  logic          m_valid, m_memRead;
  logic [AW-1:0] m_rt;
  logic          m_init;
  int unsigned   m_bubbles, m_flushes;

  function automatic logic [BW-1:0] id_word();
    return {id_regDest, id_memRead, id_memToReg, id_aluOp, id_memWrite, id_aluSrc,
            id_regWrite, id_branch, id_valid, id_rs_data, id_rt_data, id_imm,
            id_pc_plus4, id_rs, id_rt, id_rd, id_funct};
  endfunction

  function automatic logic [BW-1:0] ex_word();
    return {ex_regDest, ex_memRead, ex_memToReg, ex_aluOp, ex_memWrite, ex_aluSrc,
            ex_regWrite, ex_branch, ex_valid, ex_rs_data, ex_rt_data, ex_imm,
            ex_pc_plus4, ex_rs, ex_rt, ex_rd, ex_funct};
  endfunction

  function automatic logic model_hazard();
    logic reads_rt;
    reads_rt = !id_aluSrc || id_memWrite || id_branch;
    return m_valid && m_memRead && (m_rt != 0) && id_valid &&
           ((m_rt == id_rs) || ((m_rt == id_rt) && reads_rt));
  endfunction

  // One clock: check combinational outputs mid-cycle, advance the model,
  // then check the registered slot just after the edge.
  task automatic step(input string tag);
    logic haz;
    @(negedge clk);
    haz = model_hazard();
    if (m_init) begin
      check({tag, ".hazard"}, 256'(hazard_o), 256'(haz));
      check({tag, ".stall"},  256'(stall_o),  256'(haz || hold_i));
    end
    if (!rst_n || flush_i || (!hold_i && haz)) begin
      m_slot = '0; m_valid = 1'b0; m_memRead = 1'b0; m_rt = '0;
    end else if (!hold_i) begin
      m_slot = id_word(); m_valid = id_valid; m_memRead = id_memRead; m_rt = id_rt;
    end
    if (!rst_n) begin
      m_bubbles = 0; m_flushes = 0;
    end else begin
      if (flush_i) m_flushes++;
      if (haz && !flush_i && !hold_i) m_bubbles++;
    end
    @(posedge clk);
    #1;
    if (!rst_n) m_init = 1'b1;
    if (m_init) check({tag, ".slot"}, 256'(ex_word()), 256'(m_slot));
`ifdef ID_EX_PERF_CNT_EN
    if (m_init) begin
      check({tag, ".bcnt"}, 256'(bubble_cnt_o), 256'(m_bubbles));
      check({tag, ".fcnt"}, 256'(flush_cnt_o),  256'(m_flushes));
    end
`endif
  endtask

  // c = {regDest, memRead, memToReg, aluOp, memWrite, aluSrc, regWrite, branch}
  task automatic set_id(input logic [7:0] c, input logic v, input logic [AW-1:0] rs,
                        input logic [AW-1:0] rt, input logic [AW-1:0] rd);
    {id_regDest, id_memRead, id_memToReg, id_aluOp, id_memWrite, id_aluSrc,
     id_regWrite, id_branch} = c;
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
    id_pc_plus4 = $urandom; id_funct = 6'($urandom);
  endtask

  localparam logic [7:0] C_RTYPE = 8'b1001_0010;
  localparam logic [7:0] C_LW    = 8'b0110_0110;
  localparam logic [7:0] C_ADDI  = 8'b0001_0110;

  task automatic randomize_id();
    logic [7:0] c;
    c = 8'($urandom);
    set_id(c, ($urandom_range(0, 9) != 0), AW'($urandom_range(0, 7)),
           AW'($urandom_range(0, 7)), AW'($urandom));
  endtask

  initial begin
    m_slot = '0; m_valid = 1'b0; m_memRead = 1'b0; m_rt = '0; m_init = 1'b0;
    m_bubbles = 0; m_flushes = 0;
    flush_i = 1'b0; hold_i = 1'b0;

    // Reset with all inputs high.
    rst_n = 1'b0;
    {id_regDest, id_memRead, id_memToReg, id_aluOp, id_memWrite, id_aluSrc,
     id_regWrite, id_branch, id_valid} = '1;
    id_rs_data = '1; id_rt_data = '1; id_imm = '1; id_pc_plus4 = '1;
    id_rs = '1; id_rt = '1; id_rd = '1; id_funct = '1;
    flush_i = 1'b1; hold_i = 1'b1;
    step("rst0");
    flush_i = 1'b0; hold_i = 1'b0;
    step("rst1");
    check("rst_valid", 256'(ex_valid), 256'(0));
    check("rst_stall", 256'(stall_o), 256'(0));
    rst_n = 1'b1;
    step("rst_release");
    check("release_rd", 256'(ex_rd), 256'(5'h1f));

    // Pass-through R-type add.
    set_id(C_RTYPE, 1'b1, 5'd1, 5'd2, 5'd3);
    id_rs_data = 32'h10;
    step("pass");
    check("pass_rd", 256'(ex_rd), 256'(3));
    check("pass_rsdata", 256'(ex_rs_data), 256'(32'h10));
    check("pass_regwrite", 256'(ex_regWrite), 256'(1));
    check("pass_valid", 256'(ex_valid), 256'(1));

    // Load-use: lw rt=5 then add rs=5.
    set_id(C_LW, 1'b1, 5'd1, 5'd5, 5'd0);
    step("lu_lw");
    set_id(C_RTYPE, 1'b1, 5'd5, 5'd2, 5'd6);
    #1;
    check("lu_hazard", 256'(hazard_o), 256'(1));
    check("lu_stall", 256'(stall_o), 256'(1));
    step("lu_bubble");
    check("lu_bubble_valid", 256'(ex_valid), 256'(0));
    check("lu_bubble_regwrite", 256'(ex_regWrite), 256'(0));
    step("lu_advance");
    check("lu_adv_rs", 256'(ex_rs), 256'(5));
    check("lu_adv_valid", 256'(ex_valid), 256'(1));

    // No false hazard: addi only reads rs; index 0 never matches.
    set_id(C_LW, 1'b1, 5'd1, 5'd5, 5'd0);
    step("nf_lw5");
    set_id(C_ADDI, 1'b1, 5'd7, 5'd5, 5'd0);
    #1;
    check("nf_addi", 256'(hazard_o), 256'(0));
    set_id(C_LW, 1'b1, 5'd1, 5'd0, 5'd0);
    step("nf_lw0");
    set_id(C_RTYPE, 1'b1, 5'd0, 5'd0, 5'd4);
    #1;
    check("nf_zero", 256'(hazard_o), 256'(0));
    step("nf_after");

    // Flush wins over hold; then hold alone freezes the slot.
    set_id(C_RTYPE, 1'b1, 5'd9, 5'd10, 5'd11);
    flush_i = 1'b1; hold_i = 1'b1;
    step("fh_both");
    check("fh_valid", 256'(ex_valid), 256'(0));
    flush_i = 1'b0; hold_i = 1'b0;
    step("fh_load");
    hold_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      randomize_id();
      step("hold");
      check("hold_rd", 256'(ex_rd), 256'(11));
    end
    hold_i = 1'b0;

`ifdef ID_EX_PERF_CNT_EN
    // 2 hazard bubbles, 1 flush, 1 hazard under hold.
    rst_n = 1'b0; step("pc_rst"); rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      set_id(C_LW, 1'b1, 5'd1, 5'd5, 5'd0); step("pc_lw");
      set_id(C_RTYPE, 1'b1, 5'd5, 5'd2, 5'd6); step("pc_bub"); step("pc_adv");
    end
    set_id(C_LW, 1'b1, 5'd1, 5'd5, 5'd0); step("pc_lw");
    set_id(C_RTYPE, 1'b1, 5'd5, 5'd2, 5'd6); hold_i = 1'b1; step("pc_hold");
    hold_i = 1'b0; flush_i = 1'b1; step("pc_flush"); flush_i = 1'b0;
    check("pc_bubble_cnt", 256'(bubble_cnt_o), 256'(2));
    check("pc_flush_cnt", 256'(flush_cnt_o), 256'(1));
`endif

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      randomize_id();
      if ($urandom_range(0, 1) == 0) begin
        id_memRead = 1'b1;
        id_rt = AW'($urandom_range(0, 7));
      end
      rst_n   = ($urandom_range(0, 49) != 0);
      flush_i = ($urandom_range(0, 9) == 0);
      hold_i  = ($urandom_range(0, 6) == 0);
      step("rand");
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register, placed directly downstream of the opcode decoder.
- Each cycle it captures the decoder's seven control bits, plus branch, register operands, the immediate and register indices, and presents them to EX.
- It contains the load-use hazard check. On a hazard it inserts a bubble and stalls IF/ID.
- It also honours branch flush and back-pressure (hold) from downstream stages.

Parameters:
- DATA_W, 32, width of register operands, immediate and pc_plus4.
- REG_AW, 5, width of register index fields.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- id_regDest, id_memRead, id_memToReg, id_aluOp, id_memWrite, id_aluSrc, id_regWrite  in  1 each  decoder control bits
- id_branch  in  1  beq decoded
- id_valid  in  1  ID slot holds a real instruction
- id_rs_data, id_rt_data, id_imm, id_pc_plus4  in  DATA_W each  operands, sign-extended immediate, PC+4
- id_rs, id_rt, id_rd  in  REG_AW each  register indices
- id_funct  in  6  funct field
- flush_i  in  1  branch taken; discard the instruction entering EX
- hold_i  in  1  downstream back-pressure; freeze EX contents
- ex_* outputs  out  same widths as the id_* inputs  registered copies (ex_regDest ... ex_funct), plus ex_valid
- stall_o  out  1  combinational; holds PC and IF/ID
- hazard_o  out  1  combinational; a load-use hazard was detected this cycle

Behaviour:
- Reset: on a rising clk edge with rst_n=0, all ex_* outputs become 0, including ex_valid and every control bit. Reset overrides all other inputs, including mid-stall.
- Load-use hazard (combinational):
  - Condition: ex_valid & ex_memRead & (ex_rt != 0) & id_valid & (ex_rt==id_rs | (ex_rt==id_rt & uses_rt)).
  - uses_rt = !id_aluSrc | id_memWrite | id_branch.
- stall_o = hazard_o | hold_i.
- Per-edge update, highest priority first:
  1. !rst_n: clear everything.
  2. flush_i: load a bubble, even when hold_i=1.
  3. hold_i: all ex_* hold their values.
  4. hazard_o: load a bubble.
  5. Otherwise: load all id_* inputs; ex_valid <= id_valid.
- Bubble: every control bit = 0, ex_branch = 0, ex_valid = 0, all data and index fields = 0. A bubble never writes a register or memory.
- Latency: exactly one cycle from id_* to ex_*. No combinational path from id_* to ex_*.
- A hazard stalls for exactly one cycle. After the bubble, ex_memRead=0, so hazard_o drops and the held ID instruction advances.
- id_valid=0 never raises hazard_o. Index 0 never matches.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- When defined:
  - Adds outputs bubble_cnt_o[31:0] and flush_cnt_o[31:0].
  - bubble_cnt_o increments on each hazard bubble actually loaded (hazard with no flush and no hold). flush_cnt_o increments on each edge with flush_i=1.
  - Both counters are cleared by reset and wrap modulo 2^32.
- When undefined: the ports and logic are absent. All other behaviour is identical.

Decomposition:
- Shared package pipe_pkg contains:
  - typedef ctrl_t: packed struct of regDest, memRead, memToReg, aluOp, memWrite, aluSrc, regWrite, branch.
  - Constant CTRL_BUBBLE = '0.
  - Localparams DATA_W and REG_AW defaults, and FUNCT_W = 6.
- Sub-module hazard_detect: purely combinational. Inputs: ex_valid, ex_memRead, ex_rt, id_valid, id_rs, id_rt, uses_rt. Output: hazard_o. It is instantiated once.
- The register and priority logic stay in id_ex_stage.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with all id_* = all-ones → every ex_* = 0 and stall_o = 0. Release → next edge loads the inputs.
- Pass-through: R-type add, id_rs=1, id_rt=2, id_rd=3, regDest=1, aluOp=1, regWrite=1, rs_data=0x10 → after one edge, ex_rd=3, ex_rs_data=0x10, ex_regWrite=1, ex_valid=1.
- Load-use: lw to rt=5 sits in EX; ID holds add with rs=5 → hazard_o=1 and stall_o=1. Next edge: ex_valid=0, all controls 0. Following edge: the add loads.
- No false hazard: lw rt=5 in EX; ID holds addi with rt=5, rs=7, aluSrc=1 → hazard_o=0. Also lw rt=0 in EX with ID rs=0 → hazard_o=0.
- Flush vs hold: flush_i=1 and hold_i=1 on the same edge → bubble loaded. hold_i=1 alone for 3 edges → ex_* unchanged and stall_o=1 throughout.
- With ID_EX_PERF_CNT_EN: 2 hazard bubbles, 1 flush, 1 hazard coinciding with hold → bubble_cnt_o=2 and flush_cnt_o=1.
